// File: rtl/irqc_pkg.sv
// irqc_pkg: shared types, defaults and priority encoder for the external interrupt controller.
//   irqc_state_t   : FSM encoding (IDLE / REQ / SVC)
//   IRQC_N_SRC_DEF : default number of interrupt source lines
//   prio_enc       : index of the lowest set bit of a 16-bit vector (0 when empty)
package irqc_pkg;

    typedef enum logic [1:0] {IRQC_IDLE, IRQC_REQ, IRQC_SVC} irqc_state_t;

    localparam int IRQC_N_SRC_DEF = 8;

    function automatic logic [3:0] prio_enc(input logic [15:0] vec);
        prio_enc = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (vec[i]) prio_enc = 4'(i);
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: per-line 2-FF synchronizer plus previous-value flop, rising-edge detect.
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high
//   d_i    in  W asynchronous lines
//   edge_o out W one-cycle pulse per synchronized rising edge (s2 & ~s3)
module irq_edge_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] edge_o
);

    logic [W-1:0] s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;

    always_comb begin
        s1_d   = d_i;
        s2_d   = s1_q;
        s3_d   = s2_q;
        edge_o = s2_q & ~s3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: external interrupt requester for the LEGv8 core (ExtIRQ/ExtIAck handshake).
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   src_i      in   N_SRC asynchronous peripheral lines, rising edge latched as pending
//   ExtIAck    in   acknowledge from the controller
//   eret_i     in   handler return
//   ExtIRQ     out  interrupt request, high only in REQ
//   irq_id     out  ID_W index of the requested/in-service source
//   pending_o  out  N_SRC pending bits
//   irq_ovf    out  sticky: edge arrived on an already-pending source
//   mask_we    in   (IRQC_MASK_EN only) mask register write enable
//   mask_wdata in   (IRQC_MASK_EN only) N_SRC mask value, 1 = may arbitrate
// Optional feature macro: IRQC_MASK_EN.
module ext_irq_ctrl
    import irqc_pkg::*;
#(
    parameter int N_SRC = IRQC_N_SRC_DEF,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_i,
    input  logic             ExtIAck,
    input  logic             eret_i,
`ifdef IRQC_MASK_EN
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
`endif
    output logic             ExtIRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending_o,
    output logic             irq_ovf
);

    irqc_state_t      state_q, state_d;
    logic [N_SRC-1:0] edge_w, pending_q, pending_d, eligible, clr;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;
    logic             ovf_q, ovf_d, grant, ack;

    irq_edge_sync #(.W(N_SRC)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (src_i),
        .edge_o (edge_w)
    );

`ifdef IRQC_MASK_EN
    logic [N_SRC-1:0] mask_q, mask_d;
    always_comb begin
        mask_d   = mask_we ? mask_wdata : mask_q;
        eligible = pending_q & mask_q;
    end
    always_ff @(posedge clk) begin
        if (reset) mask_q <= '1;
        else       mask_q <= mask_d;
    end
`else
    always_comb eligible = pending_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IRQC_IDLE;
            irq_id_q  <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    // An edge landing on the bit being cleared wins, so the source stays pending.
    always_comb begin
        grant     = (state_q == IRQC_IDLE) && (|eligible);
        ack       = (state_q == IRQC_REQ) && ExtIAck;
        state_d   = grant ? IRQC_REQ :
                    ack ? IRQC_SVC :
                    (state_q == IRQC_SVC && eret_i) ? IRQC_IDLE : state_q;
        irq_id_d  = grant ? ID_W'(prio_enc(16'(eligible))) : irq_id_q;
        clr       = ack ? (N_SRC'(1) << irq_id_q) : '0;
        pending_d = (pending_q & ~clr) | edge_w;
        ovf_d     = ovf_q | (|(edge_w & pending_q));
    end

    always_comb begin
        ExtIRQ    = (state_q == IRQC_REQ);
        irq_id    = irq_id_q;
        pending_o = pending_q;
        irq_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
module tb_ext_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] src_i = '0;
    logic       ExtIAck = 1'b0;
    logic       eret_i = 1'b0;
    logic       ExtIRQ;
    logic [2:0] irq_id;
    logic [7:0] pending_o;
    logic       irq_ovf;
`ifdef IRQC_MASK_EN
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = '0;
`endif

    int errors = 0;
    int checks = 0;
    logic [2:0] sb[$];
    logic [2:0] exp_id;
    bit ok;

    always #5 clk = ~clk;

    ext_irq_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_i      (src_i),
        .ExtIAck    (ExtIAck),
        .eret_i     (eret_i),
`ifdef IRQC_MASK_EN
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
`endif
        .ExtIRQ     (ExtIRQ),
        .irq_id     (irq_id),
        .pending_o  (pending_o),
        .irq_ovf    (irq_ovf)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_irq(output bit found);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (ExtIRQ) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic service();
        ExtIAck = 1'b1;
        tick(1);
        ExtIAck = 1'b0;
        eret_i = 1'b1;
        tick(1);
        eret_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        checks++;
        if (ExtIRQ !== 1'b0 || irq_id !== 3'd0 || pending_o !== 8'h00 || irq_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: irq=%b id=%0d pend=%h ovf=%b, want 0/0/00/0", ExtIRQ, irq_id, pending_o, irq_ovf);
        end
    endtask

    task automatic test_latency();
        src_i[5] = 1'b1;
        sb.push_back(3'd5);
        tick(1);
        tick(1);
        checks++;
        if (pending_o !== 8'h00) begin
            errors++;
            $display("FAIL lat_k1: pend=%h want 00", pending_o);
        end
        tick(1);
        checks++;
        if (pending_o !== 8'h20 || ExtIRQ !== 1'b0) begin
            errors++;
            $display("FAIL lat_k2: pend=%h irq=%b want 20/0", pending_o, ExtIRQ);
        end
        tick(1);
        checks++;
        if (ExtIRQ !== 1'b1) begin
            errors++;
            $display("FAIL lat_k3: irq=%b want 1", ExtIRQ);
        end else if (sb.size() != 0) begin
            exp_id = sb.pop_front();
            checks++;
            if (irq_id !== exp_id) begin
                errors++;
                $display("FAIL lat_id: id=%0d want %0d", irq_id, exp_id);
            end
        end
        ExtIAck = 1'b1;
        tick(1);
        ExtIAck = 1'b0;
        checks++;
        if (ExtIRQ !== 1'b0 || pending_o !== 8'h00) begin
            errors++;
            $display("FAIL lat_ack: irq=%b pend=%h want 0/00", ExtIRQ, pending_o);
        end
        eret_i = 1'b1;
        tick(1);
        eret_i = 1'b0;
        src_i = '0;
    endtask

    task automatic test_priority();
        src_i = 8'h44;
        sb.push_back(3'd2);
        sb.push_back(3'd6);
        wait_irq(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL prio_first: no request, want id 2");
        end else begin
            exp_id = sb.pop_front();
            checks++;
            if (irq_id !== exp_id) begin
                errors++;
                $display("FAIL prio_first_id: id=%0d want %0d", irq_id, exp_id);
            end
        end
        ExtIAck = 1'b1;
        tick(1);
        ExtIAck = 1'b0;
        checks++;
        if (ExtIRQ !== 1'b0 || irq_id !== 3'd2) begin
            errors++;
            $display("FAIL prio_svc: irq=%b id=%0d want 0/2", ExtIRQ, irq_id);
        end
        eret_i = 1'b1;
        tick(1);
        eret_i = 1'b0;
        checks++;
        if (ExtIRQ !== 1'b0) begin
            errors++;
            $display("FAIL prio_gap: irq=%b want 0 in idle gap", ExtIRQ);
        end
        tick(1);
        checks++;
        if (ExtIRQ !== 1'b1) begin
            errors++;
            $display("FAIL prio_second: irq=%b want 1", ExtIRQ);
        end else begin
            exp_id = sb.pop_front();
            checks++;
            if (irq_id !== exp_id) begin
                errors++;
                $display("FAIL prio_second_id: id=%0d want %0d", irq_id, exp_id);
            end
        end
        service();
        src_i = '0;
    endtask

    task automatic test_hold_no_preempt();
        src_i[3] = 1'b1;
        sb.push_back(3'd3);
        wait_irq(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_req: no request, want id 3");
        end else begin
            exp_id = sb.pop_front();
            checks++;
            if (irq_id !== exp_id) begin
                errors++;
                $display("FAIL hold_req_id: id=%0d want %0d", irq_id, exp_id);
            end
        end
        src_i[0] = 1'b1;
        sb.push_back(3'd0);
        for (int c = 0; c < 20; c++) begin
            eret_i = (c % 4 == 0);
            tick(1);
            checks++;
            if (ExtIRQ !== 1'b1 || irq_id !== 3'd3) begin
                errors++;
                $display("FAIL hold_c%0d: irq=%b id=%0d want 1/3", c, ExtIRQ, irq_id);
            end
        end
        eret_i = 1'b0;
        service();
        wait_irq(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_after: no request, want id 0");
        end else begin
            exp_id = sb.pop_front();
            checks++;
            if (irq_id !== exp_id) begin
                errors++;
                $display("FAIL hold_after_id: id=%0d want %0d", irq_id, exp_id);
            end
        end
        service();
        src_i = '0;
    endtask

    task automatic test_coalesce();
        src_i[1] = 1'b1;
        sb.push_back(3'd1);
        tick(2);
        src_i[1] = 1'b0;
        tick(2);
        src_i[1] = 1'b1;
        tick(2);
        src_i[1] = 1'b0;
        tick(3);
        wait_irq(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL coal_req: no request, want id 1");
        end else begin
            exp_id = sb.pop_front();
            checks++;
            if (irq_id !== exp_id) begin
                errors++;
                $display("FAIL coal_id: id=%0d want %0d", irq_id, exp_id);
            end
        end
        checks++;
        if (irq_ovf !== 1'b1) begin
            errors++;
            $display("FAIL coal_ovf: ovf=%b want 1", irq_ovf);
        end
        ExtIAck = 1'b1;
        tick(1);
        ExtIAck = 1'b0;
        checks++;
        if (pending_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL coal_clr: pend=%h want bit1=0", pending_o);
        end
        eret_i = 1'b1;
        tick(1);
        eret_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            checks++;
            if (ExtIRQ !== 1'b0) begin
                errors++;
                $display("FAIL coal_single_c%0d: irq=%b want 0", c, ExtIRQ);
            end
        end
    endtask

    task automatic test_reset_in_svc();
        src_i[4] = 1'b1;
        sb.push_back(3'd4);
        wait_irq(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rsvc_req: no request, want id 4");
        end else begin
            exp_id = sb.pop_front();
            checks++;
            if (irq_id !== exp_id) begin
                errors++;
                $display("FAIL rsvc_id: id=%0d want %0d", irq_id, exp_id);
            end
        end
        ExtIAck = 1'b1;
        tick(1);
        ExtIAck = 1'b0;
        src_i = 8'h1C;
        tick(4);
        checks++;
        if (pending_o !== 8'h0C || ExtIRQ !== 1'b0) begin
            errors++;
            $display("FAIL rsvc_pend: pend=%h irq=%b want 0c/0", pending_o, ExtIRQ);
        end
        src_i = '0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (ExtIRQ !== 1'b0 || pending_o !== 8'h00 || irq_ovf !== 1'b0 || irq_id !== 3'd0) begin
            errors++;
            $display("FAIL rsvc_after: irq=%b pend=%h ovf=%b id=%0d want 0/00/0/0", ExtIRQ, pending_o, irq_ovf, irq_id);
        end
        tick(3);
        checks++;
        if (ExtIRQ !== 1'b0 || pending_o !== 8'h00) begin
            errors++;
            $display("FAIL rsvc_idle: irq=%b pend=%h want 0/00", ExtIRQ, pending_o);
        end
    endtask

`ifdef IRQC_MASK_EN
    task automatic test_mask();
        mask_we = 1'b1;
        mask_wdata = 8'hFE;
        tick(1);
        mask_we = 1'b0;
        src_i[0] = 1'b1;
        tick(6);
        checks++;
        if (pending_o !== 8'h01 || ExtIRQ !== 1'b0) begin
            errors++;
            $display("FAIL mask_hold: pend=%h irq=%b want 01/0", pending_o, ExtIRQ);
        end
        sb.push_back(3'd0);
        mask_we = 1'b1;
        mask_wdata = 8'hFF;
        tick(1);
        mask_we = 1'b0;
        wait_irq(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mask_req: no request after unmask, want id 0");
        end else begin
            exp_id = sb.pop_front();
            checks++;
            if (irq_id !== exp_id) begin
                errors++;
                $display("FAIL mask_id: id=%0d want %0d", irq_id, exp_id);
            end
        end
        service();
        src_i = '0;
    endtask
`endif

    initial begin
        tick(1);
        test_reset();
        test_latency();
        test_priority();
        test_hold_no_preempt();
        test_coalesce();
        test_reset_in_svc();
`ifdef IRQC_MASK_EN
        test_mask();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
